// File: rtl/data_sram_to_sramlike.sv
// Bridges the MEM-stage single-cycle SRAM data port to the split-transaction
// SRAM-like port, stalling the pipeline until data_ok and holding the result.
module data_sram_to_sramlike #(
  parameter bit ALIGN_READ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        longest_stall,
  output logic        d_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  // Handshake: a request is accepted on a cycle where data_req & data_addr_ok;
  // the transaction completes on the first data_data_ok at or after acceptance.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] rdata_r;
  logic        complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (data_sram_en) begin
          if (data_addr_ok && data_data_ok) state_next = DONE;
          else if (data_addr_ok)            state_next = DATA;
          else                              state_next = ADDR;
        end
      end
      ADDR: begin
        if (data_addr_ok && data_data_ok) state_next = DONE;
        else if (data_addr_ok)            state_next = DATA;
      end
      DATA: begin
        if (data_data_ok) state_next = DONE;
      end
      DONE: begin
        if (!longest_stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only the data_ok that actually finishes the transaction is captured.
  assign complete = (state != DONE) && (state_next == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 32'd0;
    end else if (complete) begin
      rdata_r <= data_rdata;
    end
  end

  always_comb begin
    data_req = 1'b0;
    d_stall  = 1'b0;
    case (state)
      IDLE: begin
        data_req = data_sram_en;
        d_stall  = data_sram_en;
      end
      ADDR: begin
        data_req = 1'b1;
        d_stall  = data_sram_en;
      end
      DATA: begin
        d_stall = data_sram_en;
      end
      DONE: begin
        d_stall = 1'b0;
      end
      default: begin
        data_req = 1'b0;
        d_stall  = 1'b0;
      end
    endcase
  end

  // Request fields come straight from the CPU; it holds them while stalled.
  always_comb begin
    data_wr    = |data_sram_wen;
    data_wdata = data_sram_wdata;
    data_addr  = data_sram_addr;
    case (data_sram_wen)
      4'b1111:                         data_size = 2'd2;
      4'b0011, 4'b1100:                data_size = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: data_size = 2'd0;
      default:                         data_size = 2'd2;
    endcase
    if (!data_wr && ALIGN_READ) begin
      data_addr = {data_sram_addr[31:2], 2'b00};
    end
  end

  assign data_sram_rdata = rdata_r;

endmodule
